dpic_mem_lsu: RTL and testbench
===============================

Name: dpic_mem_lsu

Overview:
Initiator side of the simulation memory port. Takes one load/store request per transaction from the core over a valid/ready interface. Drives the memory model's read/write port (rd_en/rd_addr/rd_data, we_en/we_addr/we_data/we_mask) for exactly one cycle, then returns a registered, size-extended response. Sits between the core's MEM stage and the DPI-C memory model in the npc playground.

Parameters:
SAFE_ADDR, 64'h8000_0000, idle/reset value on mem_rd_addr/mem_we_addr; keeps the DPI read in the valid pmem range.

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when high with req_valid
req_wen  input  1  1 = store, 0 = load
req_size  input  2  0=1B, 1=2B, 2=4B, 3=8B
req_signed  input  1  load sign-extend (ignored for stores)
req_addr  input  64  byte address
req_wdata  input  64  store data, LSB-aligned
resp_valid  output  1  response valid
resp_ready  input  1  response consumed when high with resp_valid
resp_rdata  output  64  extended load data; 0 for stores
resp_err  output  1  misaligned access (see Optional Feature)
mem_rd_en  output  1  memory read enable
mem_rd_addr  output  64  memory read address
mem_rd_data  input  64  memory read data, combinational, bytes starting at mem_rd_addr
mem_we_en  output  1  memory write enable
mem_we_addr  output  64  memory write address
mem_we_data  output  64  memory write data
mem_we_mask  output  8  byte mask

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n). All state registers reset asynchronously.
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: req_ready=1 (IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_rd_en=0, mem_we_en=0, mem_we_data=0, mem_we_mask=0, mem_rd_addr=mem_we_addr=SAFE_ADDR.
- IDLE: req_ready=1.
  - On req_valid & req_ready, register wen, size, signed, addr and wdata, then go to ACCESS.
- ACCESS, exactly one cycle:
  - req_ready=0.
  - mem_rd_addr and mem_we_addr = registered addr.
  - Load: mem_rd_en=1. Sample mem_rd_data at the end of the cycle and keep the low 1/2/4/8 bytes. Sign-extend if signed, else zero-extend, into resp_rdata.
  - Store: mem_we_en=1, mem_we_data = wdata with bytes above size zeroed, mem_we_mask = 8'h01/8'h03/8'h0F/8'hFF for size 0/1/2/3. resp_rdata=0.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until the handshake.
  - mem_rd_en=mem_we_en=0; addresses keep their last value.
  - On resp_ready go to IDLE. req_ready rises the following cycle; there is no same-cycle bypass.
- Latency and throughput: accept at cycle N, memory access at N+1, resp_valid at N+2. Minimum 3 cycles per transaction.
- mem_we_en and mem_rd_en are never high together and only ever high in ACCESS.
- Reset mid-operation: reset_n low in any state returns immediately to IDLE with reset values. The in-flight request is dropped and no write is issued after reset deasserts.
- req_* inputs change while not in IDLE: ignored, since they were registered at acceptance.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: an access is misaligned when (addr & ((1<<size)-1)) != 0.
  - In ACCESS, mem_rd_en and mem_we_en stay 0.
  - The response arrives with the normal latency, with resp_err=1 and resp_rdata=0.
- Undefined: no check; misaligned accesses proceed normally and resp_err is tied 0.

Test Plan:
- Reset, then release with no requests -> req_ready=1, resp_valid=0, mem_rd_addr=0x8000_0000, both enables 0.
- Load size=0, signed=1, addr=0x8000_0010, memory returns 0x...0080 -> mem_rd_en high for exactly 1 cycle; resp_rdata=0xFFFF_FFFF_FFFF_FF80 two cycles after accept.
- Store size=2, addr=0x8000_0020, wdata=0x1122_3344_5566_7788 -> one-cycle mem_we_en, mem_we_mask=0x0F, mem_we_data=0x0000_0000_5566_7788; resp_rdata=0, resp_err=0.
- Hold resp_ready=0 for 5 cycles while a new req_valid is asserted -> resp_valid and data stable, req_ready=0 throughout; new request accepted the cycle after resp_ready=1.
- reset_n pulsed low during ACCESS of a store -> mem_we_en drops immediately; after release no write and no response occur.
- With LSU_MISALIGN_CHECK_EN: load size=3, addr=0x8000_0004 -> no memory enable, resp_err=1, resp_rdata=0. Without it: normal 8-byte read, resp_err=0.

Source files
------------

// File: rtl/dpic_mem_lsu.sv
// Load/store initiator for the DPI-C simulation memory: one request per transaction, single-cycle memory access, registered response.
// Optional misalignment check: define LSU_MISALIGN_CHECK_EN to flag misaligned accesses with resp_err.
module dpic_mem_lsu #(
  parameter logic [63:0] SAFE_ADDR = 64'h8000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  // Handshake: a transfer happens on a rising clock edge where valid and ready are both high.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]  r_state;
  logic        r_wen;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_in_access;
  logic        w_misalign;
  logic [7:0]  w_byte_mask;
  logic [63:0] w_bit_mask;
  logic [63:0] w_load_ext;

  function automatic logic [63:0] f_extend(input logic [63:0] d, input logic [1:0] sz,
                                           input logic sgn);
    logic [63:0] v;
    v = d;
    case (sz)
      2'd0:    v = sgn ? {{56{d[7]}},  d[7:0]}  : {56'd0, d[7:0]};
      2'd1:    v = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      2'd2:    v = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  assign w_in_access = (r_state == ST_ACCESS);

  always_comb begin
    w_byte_mask = 8'hFF;
    case (r_size)
      2'd0:    w_byte_mask = 8'h01;
      2'd1:    w_byte_mask = 8'h03;
      2'd2:    w_byte_mask = 8'h0F;
      default: w_byte_mask = 8'hFF;
    endcase
  end

  always_comb begin
    w_bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_bit_mask[i*8 +: 8] = {8{w_byte_mask[i]}};
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  // Low address bits that must be zero for the access size: size 0 -> none, 3 -> [2:0].
  logic [2:0] w_align_bits;
  always_comb begin
    w_align_bits = 3'b111;
    case (r_size)
      2'd0:    w_align_bits = 3'b000;
      2'd1:    w_align_bits = 3'b001;
      2'd2:    w_align_bits = 3'b011;
      default: w_align_bits = 3'b111;
    endcase
  end
  assign w_misalign = |(r_addr[2:0] & w_align_bits);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_load_ext = f_extend(mem_rd_data, r_size, r_signed);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_wen    <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_addr   <= SAFE_ADDR;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wen    <= req_wen;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_state  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_rd_data is combinational from the model, so it is valid at this edge.
          r_rdata <= (r_wen || w_misalign) ? 64'd0 : w_load_ext;
          r_err   <= w_misalign;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign dbg_state   = r_state;

  // Enables derive from the state register so an asynchronous reset drops them at once.
  assign mem_rd_en   = w_in_access & ~r_wen & ~w_misalign;
  assign mem_we_en   = w_in_access &  r_wen & ~w_misalign;
  assign mem_rd_addr = (r_state == ST_IDLE) ? SAFE_ADDR : r_addr;
  assign mem_we_addr = (r_state == ST_IDLE) ? SAFE_ADDR : r_addr;
  assign mem_we_data = mem_we_en ? (r_wdata & w_bit_mask) : 64'd0;
  assign mem_we_mask = mem_we_en ? w_byte_mask : 8'h00;

endmodule

// File: tb/tb_dpic_mem_lsu.sv
// Directed bench for dpic_mem_lsu: loads of every size/sign, stores, response back-pressure, mid-access reset, misalignment.
module tb_dpic_mem_lsu;

  localparam logic [63:0] SAFE = 64'h8000_0000;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_we_en;
  logic [63:0] mem_we_addr;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  dpic_mem_lsu dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_we_en   (mem_we_en),
    .mem_we_addr (mem_we_addr),
    .mem_we_data (mem_we_data),
    .mem_we_mask (mem_we_mask),
    .dbg_state   (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rd_data = '0;
    tick; tick;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if ({mem_rd_en, mem_we_en} !== 2'b00) begin failures++; $display("FAIL rst_enables got=%b exp=00", {mem_rd_en, mem_we_en}); end
    checks++; if (mem_rd_addr !== SAFE || mem_we_addr !== SAFE) begin failures++; $display("FAIL rst_addrs got=%h/%h exp=%h", mem_rd_addr, mem_we_addr, SAFE); end
    checks++; if (mem_we_data !== 64'd0 || mem_we_mask !== 8'h00) begin failures++; $display("FAIL rst_we_data got=%h/%h exp=0/0", mem_we_data, mem_we_mask); end
    checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got=%h/%b exp=0/0", resp_rdata, resp_err); end
    reset_n = 1'b1;
    tick; tick;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL idle_hs got=%b%b exp=10", req_ready, resp_valid); end
    checks++; if (mem_rd_addr !== SAFE) begin failures++; $display("FAIL idle_rd_addr got=%h exp=%h", mem_rd_addr, SAFE); end
    checks++; if ({mem_rd_en, mem_we_en} !== 2'b00) begin failures++; $display("FAIL idle_enables got=%b exp=00", {mem_rd_en, mem_we_en}); end
  endtask

  task automatic test_load_vec(input string name, input logic [1:0] sz, input logic sgn,
                               input logic [63:0] addr, input logic [63:0] mdata,
                               input logic [63:0] exp);
    req_valid = 1'b1; req_wen = 1'b0; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = 64'h5A5A_5A5A_5A5A_5A5A; mem_rd_data = mdata; resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", name, req_ready); end
    tick;
    // Scramble request inputs: the access must use the captured values.
    req_valid = 1'b0; req_addr = 64'hDEAD_BEEF_0000_0000; req_size = ~sz; req_signed = ~sgn; req_wen = 1'b1;
    checks++; if ({mem_rd_en, mem_we_en} !== 2'b10) begin failures++; $display("FAIL %s_access_en got=%b exp=10", name, {mem_rd_en, mem_we_en}); end
    checks++; if (mem_rd_addr !== addr) begin failures++; $display("FAIL %s_rd_addr got=%h exp=%h", name, mem_rd_addr, addr); end
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL %s_access_hs got=%b%b exp=00", name, req_ready, resp_valid); end
    tick;
    mem_rd_data = 64'd0;
    #1;
    checks++; if (resp_valid !== 1'b1 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL %s_resp got=v%b en%b exp=v1 en0", name, resp_valid, mem_rd_en); end
    checks++; if (resp_rdata !== exp) begin failures++; $display("FAIL %s_rdata got=%h exp=%h", name, resp_rdata, exp); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL %s_err got=%b exp=0", name, resp_err); end
    checks++; if (mem_rd_addr !== addr) begin failures++; $display("FAIL %s_resp_addr got=%h exp=%h", name, mem_rd_addr, addr); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL %s_back_idle got=%b%b exp=10", name, req_ready, resp_valid); end
    checks++; if (mem_rd_addr !== SAFE) begin failures++; $display("FAIL %s_idle_addr got=%h exp=%h", name, mem_rd_addr, SAFE); end
  endtask

  task automatic test_loads;
    test_load_vec("lb_s",  2'd0, 1'b1, 64'h8000_0010, 64'h0000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FF80);
    test_load_vec("lbu",   2'd0, 1'b0, 64'h8000_0011, 64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080);
    test_load_vec("lh_s",  2'd1, 1'b1, 64'h8000_0012, 64'h1234_5678_9ABC_8001, 64'hFFFF_FFFF_FFFF_8001);
    test_load_vec("lhu",   2'd1, 1'b0, 64'h8000_0012, 64'h1234_5678_9ABC_8001, 64'h0000_0000_0000_8001);
    test_load_vec("lw_s",  2'd2, 1'b1, 64'h8000_0014, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_8765_4321);
    test_load_vec("lwu",   2'd2, 1'b0, 64'h8000_0014, 64'h1234_5678_8765_4321, 64'h0000_0000_8765_4321);
    test_load_vec("lw_sp", 2'd2, 1'b1, 64'h8000_0018, 64'hFFFF_FFFF_7654_3210, 64'h0000_0000_7654_3210);
    test_load_vec("ld",    2'd3, 1'b1, 64'h8000_0018, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211);
  endtask

  task automatic test_store_vec(input string name, input logic [1:0] sz, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_data,
                                input logic [7:0] exp_mask);
    req_valid = 1'b1; req_wen = 1'b1; req_size = sz; req_signed = 1'b1;
    req_addr = addr; req_wdata = wdata; mem_rd_data = 64'hFFFF_FFFF_FFFF_FFFF; resp_ready = 1'b0;
    tick;
    req_valid = 1'b0; req_wdata = 64'hFFFF_0000_FFFF_0000; req_addr = 64'h0;
    checks++; if ({mem_rd_en, mem_we_en} !== 2'b01) begin failures++; $display("FAIL %s_access_en got=%b exp=01", name, {mem_rd_en, mem_we_en}); end
    checks++; if (mem_we_addr !== addr) begin failures++; $display("FAIL %s_we_addr got=%h exp=%h", name, mem_we_addr, addr); end
    checks++; if (mem_we_data !== exp_data) begin failures++; $display("FAIL %s_we_data got=%h exp=%h", name, mem_we_data, exp_data); end
    checks++; if (mem_we_mask !== exp_mask) begin failures++; $display("FAIL %s_we_mask got=%h exp=%h", name, mem_we_mask, exp_mask); end
    tick;
    checks++; if (resp_valid !== 1'b1 || mem_we_en !== 1'b0) begin failures++; $display("FAIL %s_resp got=v%b we%b exp=v1 we0", name, resp_valid, mem_we_en); end
    checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin failures++; $display("FAIL %s_resp_data got=%h/%b exp=0/0", name, resp_rdata, resp_err); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL %s_back_idle got=%b%b exp=10", name, req_ready, resp_valid); end
  endtask

  task automatic test_stores;
    test_store_vec("sw", 2'd2, 64'h8000_0020, 64'h1122_3344_5566_7788, 64'h0000_0000_5566_7788, 8'h0F);
    test_store_vec("sb", 2'd0, 64'h8000_0021, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_0088, 8'h01);
    test_store_vec("sh", 2'd1, 64'h8000_0022, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_7788, 8'h03);
    test_store_vec("sd", 2'd3, 64'h8000_0028, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 8'hFF);
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 64'h8000_0030; mem_rd_data = 64'h0000_0000_9999_ABCD; resp_ready = 1'b0;
    tick;
    // Next request is a store, presented while the load response is back-pressured.
    req_wen = 1'b1; req_size = 2'd3; req_addr = 64'h8000_0040; req_wdata = 64'h0102_0304_0506_0708;
    tick;
    mem_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h0000_0000_0000_ABCD) begin failures++; $display("FAIL hold_resp_%0d got=v%b %h exp=v1 %h", i, resp_valid, resp_rdata, 64'h0000_0000_0000_ABCD); end
      checks++; if (req_ready !== 1'b0 || mem_we_en !== 1'b0 || mem_rd_en !== 1'b0) begin failures++; $display("FAIL hold_quiet_%0d got=%b%b%b exp=000", i, req_ready, mem_we_en, mem_rd_en); end
      tick;
    end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    tick;
    req_valid = 1'b0;
    checks++; if (mem_we_en !== 1'b1 || mem_we_addr !== 64'h8000_0040) begin failures++; $display("FAIL b2b_store got=%b %h exp=1 %h", mem_we_en, mem_we_addr, 64'h8000_0040); end
    checks++; if (mem_we_data !== 64'h0102_0304_0506_0708) begin failures++; $display("FAIL b2b_we_data got=%h exp=%h", mem_we_data, 64'h0102_0304_0506_0708); end
    tick;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b%b exp=10", req_ready, resp_valid); end
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3; req_addr = 64'h8000_0050;
    req_wdata = 64'hAAAA_BBBB_CCCC_DDDD; resp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    checks++; if (mem_we_en !== 1'b1) begin failures++; $display("FAIL mid_we_before got=%b exp=1", mem_we_en); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_we_en !== 1'b0 || mem_we_mask !== 8'h00) begin failures++; $display("FAIL mid_we_drop got=%b %h exp=0 00", mem_we_en, mem_we_mask); end
    checks++; if (req_ready !== 1'b1 || mem_we_addr !== SAFE) begin failures++; $display("FAIL mid_idle got=%b %h exp=1 %h", req_ready, mem_we_addr, SAFE); end
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (mem_we_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_after_%0d got=we%b v%b r%b exp=we0 v0 r1", i, mem_we_en, resp_valid, req_ready); end
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_misalign;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic        exp_rd_en;
`ifdef LSU_MISALIGN_CHECK_EN
    exp_rdata = 64'd0; exp_err = 1'b1; exp_rd_en = 1'b0;
`else
    exp_rdata = 64'hCAFE_F00D_1234_5678; exp_err = 1'b0; exp_rd_en = 1'b1;
`endif
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 64'h8000_0004; mem_rd_data = 64'hCAFE_F00D_1234_5678; resp_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    checks++; if (mem_rd_en !== exp_rd_en || mem_we_en !== 1'b0) begin failures++; $display("FAIL mis_en got=%b%b exp=%b0", mem_rd_en, mem_we_en, exp_rd_en); end
    tick;
    checks++; if (resp_valid !== 1'b1 || resp_err !== exp_err) begin failures++; $display("FAIL mis_err got=v%b e%b exp=v1 e%b", resp_valid, resp_err, exp_err); end
    checks++; if (resp_rdata !== exp_rdata) begin failures++; $display("FAIL mis_rdata got=%h exp=%h", resp_rdata, exp_rdata); end
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mis_idle got=%b exp=1", req_ready); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_loads;
    test_stores;
    test_back_to_back;
    test_reset_mid;
    test_misalign;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
